// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-add/full-subtract cell, LSB first,
// registered carry/borrow, start/busy/done handshake. WIDTH+1 cycles per op.

module serial_add_sub_cell (
  input  logic mode,
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ c;
  // mode=1: borrow out of a-b-c; mode=0: carry out of a+b+c
  assign co = mode ? ((~a & b) | (~(a ^ b) & c))
                   : ((a & b) | (c & (a ^ b)));
endmodule

module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);
  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nxt, a_shr, b_shr;
  logic [CW-1:0]    cnt;
  logic             mode_r, carry, s_bit, c_nxt, accept;

  serial_add_sub_cell u_cell (
    .mode (mode_r),
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .c    (carry),
    .s    (s_bit),
    .co   (c_nxt)
  );

  // Shift right with the new bit entering at the MSB; written this way so
  // WIDTH=1 needs no special slice.
  always_comb begin
    acc_nxt            = acc >> 1;
    acc_nxt[WIDTH-1]   = s_bit;
    a_shr              = a_sh >> 1;
    b_shr              = b_sh >> 1;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept    = 1'b1;
        state_nxt = RUN;
      end
      RUN:  if (cnt == LAST) state_nxt = DONE;
      DONE: begin
        accept    = start;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      cnt    <= '0;
      mode_r <= 1'b0;
      carry  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_sh   <= a;
        b_sh   <= b;
        mode_r <= mode;
        carry  <= cin;
        cnt    <= '0;
        acc    <= '0;
      end else if (state == RUN) begin
        a_sh  <= a_shr;
        b_sh  <= b_shr;
        carry <= c_nxt;
        cnt   <= cnt + CW'(1);
        acc   <= acc_nxt;
        if (cnt == LAST) begin
          result <= acc_nxt;
          cout   <= c_nxt;
        end
      end
    end
  end
endmodule
